// File: rtl/ss_display_arbiter.sv
// ss_display_arbiter: round-robin share of a 4-digit seven-segment display between requesters A and B with sequential BCD conversion
// Ports: Clk/Reset (sync, active-high); ReqA/ValA/BrtA and ReqB/ValB/BrtB requests; AckA/AckB grant pulses;
// BCD3..BCD0 displayed digits, PwmOut brightness, Owner source id, Ovf saturation flag, Done update pulse, Busy.
module ss_display_arbiter #(
  parameter int HOLD_CYCLES = 100000000,
  parameter int HOLD_W = 27
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqA,
  input  logic [13:0] ValA,
  input  logic [7:0]  BrtA,
  input  logic        ReqB,
  input  logic [13:0] ValB,
  input  logic [7:0]  BrtB,
  output logic        AckA,
  output logic        AckB,
  output logic [3:0]  BCD3,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD0,
  output logic [7:0]  PwmOut,
  output logic        Owner,
  output logic        Ovf,
  output logic        Done,
  output logic        Busy
);
  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;
  state_t state, state_n;
  logic last, last_n;
  logic [3:0] cnt, cnt_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [13:0] bin, bin_n, sh_bin, val;
  logic [15:0] bcd, bcd_n, adj, sh_bcd, disp, disp_n;
  logic [7:0] brt, brt_n, pwm, pwm_n;
  logic own, own_n, sat, sat_n, owner, owner_n, ovf, ovf_n;
  logic ack_a, ack_a_n, ack_b, ack_b_n, done, done_n, busy, busy_n;
  logic gnt_b, big;
  // B wins when it is alone, or on a tie when A was served last
  assign gnt_b = ReqB & (~ReqA | ~last);
  assign val = gnt_b ? ValB : ValA;
  assign big = val > 14'd9999;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign {sh_bcd, sh_bin} = {adj[14:0], bin, 1'b0};
  always_comb begin
    state_n = state;
    last_n = last;
    cnt_n = cnt;
    hold_n = hold;
    bin_n = bin;
    bcd_n = bcd;
    brt_n = brt;
    own_n = own;
    sat_n = sat;
    disp_n = disp;
    pwm_n = pwm;
    owner_n = owner;
    ovf_n = ovf;
    ack_a_n = 1'b0;
    ack_b_n = 1'b0;
    done_n = 1'b0;
    busy_n = busy;
    case (state)
      IDLE: if (ReqA | ReqB) begin
        state_n = CONVERT;
        last_n = gnt_b;
        ack_a_n = ~gnt_b;
        ack_b_n = gnt_b;
        bin_n = big ? 14'd9999 : val;
        sat_n = big;
        brt_n = gnt_b ? BrtB : BrtA;
        own_n = gnt_b;
        bcd_n = '0;
        cnt_n = 4'd13;
        busy_n = 1'b1;
      end
      CONVERT: begin
        bin_n = sh_bin;
        bcd_n = sh_bcd;
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd0) begin
          state_n = HOLD;
          hold_n = HOLD_W'(HOLD_CYCLES - 1);
          disp_n = sh_bcd;
          pwm_n = brt;
          owner_n = own;
          ovf_n = sat;
          done_n = 1'b1;
        end
      end
      HOLD: begin
        hold_n = hold - HOLD_W'(1);
        if (hold == '0) begin
          state_n = IDLE;
          busy_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      last <= 1'b1;
      cnt <= '0;
      hold <= '0;
      bin <= '0;
      bcd <= '0;
      brt <= '0;
      own <= 1'b0;
      sat <= 1'b0;
      disp <= '0;
      pwm <= '0;
      owner <= 1'b0;
      ovf <= 1'b0;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      last <= last_n;
      cnt <= cnt_n;
      hold <= hold_n;
      bin <= bin_n;
      bcd <= bcd_n;
      brt <= brt_n;
      own <= own_n;
      sat <= sat_n;
      disp <= disp_n;
      pwm <= pwm_n;
      owner <= owner_n;
      ovf <= ovf_n;
      ack_a <= ack_a_n;
      ack_b <= ack_b_n;
      done <= done_n;
      busy <= busy_n;
    end
  end
  assign {BCD3, BCD2, BCD1, BCD0} = disp;
  assign PwmOut = pwm;
  assign Owner = owner;
  assign Ovf = ovf;
  assign AckA = ack_a;
  assign AckB = ack_b;
  assign Done = done;
  assign Busy = busy;
endmodule

// File: tb/tb_ss_display_arbiter.sv
// tb_ss_display_arbiter: directed and random checks of ss_display_arbiter against a decimal-arithmetic reference model
module tb_ss_display_arbiter;
  localparam int HOLD = 4;
  logic Clk = 1'b0, Reset = 1'b1, ReqA = 1'b0, ReqB = 1'b0;
  logic [13:0] ValA = '0, ValB = '0;
  logic [7:0] BrtA = '0, BrtB = '0;
  logic AckA, AckB, Owner, Ovf, Done, Busy;
  logic [3:0] BCD3, BCD2, BCD1, BCD0;
  logic [7:0] PwmOut;
  int n_chk = 0, n_fail = 0;
  logic last_b = 1'b1;
  ss_display_arbiter #(.HOLD_CYCLES(HOLD), .HOLD_W(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA(ReqA), .ValA(ValA), .BrtA(BrtA),
    .ReqB(ReqB), .ValB(ValB), .BrtB(BrtB),
    .AckA(AckA), .AckB(AckB),
    .BCD3(BCD3), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0),
    .PwmOut(PwmOut), .Owner(Owner), .Ovf(Ovf), .Done(Done), .Busy(Busy)
  );
  always #5 Clk = ~Clk;
  initial begin
    #1ms;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic step;
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic pick(input logic a, input logic b);
    if (a && b) return !last_b;
    return b;
  endfunction
  task automatic chk_zero(input string tag);
    chk({BCD3, BCD2, BCD1, BCD0}, 0, {tag, "_bcd"});
    chk(PwmOut, 0, {tag, "_pwm"});
    chk({Owner, Ovf, AckA, AckB, Done, Busy}, 0, {tag, "_flags"});
  endtask
  task automatic do_reset;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    last_b = 1'b1;
    chk_zero("reset");
  endtask
  // Waits for the predicted grant, then checks latency, the displayed result and the hold time
  task automatic serve(input logic exp_b, input logic keep, input int chg_a, input logic raise_b);
    int k, v, b, s;
    k = 0;
    while (!(AckA || AckB) && k < 100) begin
      step();
      k++;
    end
    chk(32'(k < 100), 1, "ack_wait");
    chk(AckB, exp_b, "grant_b");
    chk(AckA, !exp_b, "grant_a");
    v = exp_b ? int'(ValB) : int'(ValA);
    b = exp_b ? int'(BrtB) : int'(BrtA);
    last_b = exp_b;
    if (!keep) begin
      if (exp_b) ReqB = 1'b0;
      else ReqA = 1'b0;
    end
    if (chg_a >= 0) ValA = 14'(chg_a);
    k = 0;
    do begin
      step();
      k++;
    end while (!Done && k < 40);
    chk(k, 14, "latency");
    s = v > 9999 ? 9999 : v;
    chk(BCD3, s / 1000, "bcd3");
    chk(BCD2, (s / 100) % 10, "bcd2");
    chk(BCD1, (s / 10) % 10, "bcd1");
    chk(BCD0, s % 10, "bcd0");
    chk(PwmOut, b, "pwm");
    chk(Owner, exp_b, "owner");
    chk(Ovf, 32'(v > 9999), "ovf");
    chk(Busy, 1, "busy");
    k = 0;
    while (Busy && k < 20) begin
      if (raise_b && k == 0) ReqB = 1'b1;
      step();
      k++;
      if (k == 1) chk(Done, 0, "done_width");
      if (Busy) chk(AckA | AckB, 0, "ack_in_hold");
    end
    chk(k, HOLD, "hold_len");
  endtask
  initial begin
    int k;
    int bnd[5] = '{0, 9, 10, 999, 1000};
    do_reset();
    ValA = 14'd1234;
    BrtA = 8'h80;
    ReqA = 1'b1;
    serve(pick(ReqA, ReqB), 0, -1, 0);
    do_reset();
    ValA = 14'd11;
    ValB = 14'd22;
    BrtA = 8'h11;
    BrtB = 8'h22;
    ReqA = 1'b1;
    ReqB = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(pick(ReqA, ReqB), 1, -1, 0);
      chk(Owner, i % 2, "alternate");
    end
    ReqA = 1'b0;
    ReqB = 1'b0;
    ValB = 14'd16383;
    ReqB = 1'b1;
    serve(pick(ReqA, ReqB), 0, -1, 0);
    ValA = 14'd9999;
    ReqA = 1'b1;
    serve(pick(ReqA, ReqB), 0, -1, 0);
    foreach (bnd[i]) begin
      ValA = 14'(bnd[i]);
      BrtA = 8'(i + 1);
      ReqA = 1'b1;
      serve(pick(ReqA, ReqB), 0, -1, 0);
    end
    ValA = 14'd5678;
    ReqA = 1'b1;
    k = 0;
    while (!AckA && k < 100) begin
      step();
      k++;
    end
    chk(AckA, 1, "abort_ack");
    ReqA = 1'b0;
    repeat (6) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    last_b = 1'b1;
    chk_zero("abort");
    repeat (20) begin
      step();
      chk(Done, 0, "abort_no_done");
    end
    ReqB = 1'b1;
    ValB = 14'd42;
    serve(pick(ReqA, ReqB), 0, -1, 0);
    ValA = 14'd4321;
    ValB = 14'd77;
    ReqA = 1'b1;
    serve(pick(ReqA, ReqB), 0, 8888, 1);
    serve(pick(ReqA, ReqB), 0, -1, 0);
    for (int i = 0; i < 10; i++) begin
      logic a, b;
      a = 1'($urandom_range(0, 1));
      b = a ? 1'($urandom_range(0, 1)) : 1'b1;
      ValA = 14'($urandom_range(0, 16383));
      ValB = 14'($urandom_range(0, 16383));
      BrtA = 8'($urandom);
      BrtB = 8'($urandom);
      ReqA = a;
      ReqB = b;
      serve(pick(ReqA, ReqB), 0, -1, 0);
      ReqA = 1'b0;
      ReqB = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ss_display_arbiter.md
Name: ss_display_arbiter

Overview:
- Shares the 4-digit seven-segment display between two requesters, A and B.
- Arbitrates between them round-robin and latches the granted 14-bit binary value and 8-bit brightness.
- Converts the value to four BCD digits with a sequential double-dabble engine.
- Drives the digit and brightness inputs of the segment driver, then holds the result for a minimum display time before granting again.

Parameters:
- HOLD_CYCLES, 100000000, minimum number of Clk cycles a converted result is held before the next grant; legal range 1 to 2^27-1.
- HOLD_W, 27, width of the hold counter; must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- Clk  input  1  system clock, 100 MHz
- Reset  input  1  synchronous, active-high reset
- ReqA  input  1  requester A wants the display; held high until AckA
- ValA  input  14  requester A binary value
- BrtA  input  8  requester A brightness (PWM duty)
- ReqB  input  1  requester B wants the display; held high until AckB
- ValB  input  14  requester B binary value
- BrtB  input  8  requester B brightness
- AckA  output  1  one-cycle pulse: A's value/brightness latched
- AckB  output  1  one-cycle pulse: B's value/brightness latched
- BCD3, BCD2, BCD1, BCD0  output  4 each  displayed digits, thousands..units
- PwmOut  output  8  brightness to segment driver
- Owner  output  1  0 = A, 1 = B; source of currently displayed data
- Ovf  output  1  displayed value was saturated
- Done  output  1  one-cycle pulse when the BCD/PwmOut update takes effect
- Busy  output  1  high in CONVERT and HOLD

Behaviour:
- Reset values: BCD3..0 = 0, PwmOut = 0, Owner = 0, Ovf = 0, AckA = AckB = 0, Done = 0, Busy = 0, state IDLE, LastGrant = B, so A wins the first tie. Reset mid-CONVERT or mid-HOLD aborts the operation; the outputs take their reset values on the next edge.
- States: IDLE, CONVERT, HOLD. All outputs are registered.
- IDLE, edge E0 with at least one Req high:
  - With one requester high, grant that requester.
  - With both high, grant the one that is not LastGrant.
  - Latch the value (saturated), the brightness and the grantee id.
  - Update LastGrant, assert the matching Ack for exactly the cycle after E0, and go to CONVERT with the bit counter at 13.
- Saturation: a latched value above 9999 is replaced by 9999, and the Ovf flag is latched with it.
- CONVERT:
  - Runs one double-dabble step per edge over edges E1..E14. Each step adds 3 to any BCD nibble that is 5 or more, then shifts left one bit, taking the MSB of the binary shift register.
  - At E14, BCD3..0, PwmOut, Owner and Ovf update together, so the display never shows a partial result.
  - Done is high for the cycle after E14. The state goes to HOLD with the counter set to HOLD_CYCLES-1.
  - Latency from the grant edge to the output update is 14 edges.
- HOLD: the counter decrements every edge. When it is 0, go to IDLE on that edge. The display is held for exactly HOLD_CYCLES cycles after the update. A new grant is possible on the first IDLE edge.
- Requests raised during CONVERT or HOLD are neither acknowledged nor lost; the requester keeps Req high.
- A Req dropped before its Ack is simply not served, with no side effect.
- Val and Brt are sampled only at the grant edge. Later changes do not affect the conversion in flight.
- Outputs stay stable in IDLE, showing the last result indefinitely.

Test Plan:
1. Reset then ReqA = 1, ValA = 1234, BrtA = 0x80, HOLD_CYCLES = 4:
   - AckA pulses 1 cycle after the grant edge.
   - Done pulses 14 edges later, with BCD3..0 = 1,2,3,4, PwmOut = 0x80, Owner = 0, Ovf = 0.
   - Busy drops 4 cycles after Done.
2. ReqA and ReqB both held high continuously, ValA = 11, ValB = 22:
   - Grants alternate A, B, A, B.
   - Displayed value alternates 0011 / 0022.
   - No Ack while Busy.
3. ValB = 16383 (all ones) -> display 9,9,9,9 with Ovf = 1. A following ValA = 9999 -> 9999 with Ovf = 0.
4. Boundary values 0, 9, 10, 999, 1000 -> BCD digits 0000, 0009, 0010, 0999, 1000.
5. Reset asserted at CONVERT step 7 of ValA = 5678:
   - Outputs become all-zero the next cycle; Done never pulses.
   - A later ReqB is granted first, because LastGrant was reset to B so A wins only ties.
6. ValA changed from 4321 to 8888 while CONVERT is in progress -> display shows 4321. ReqB raised during HOLD is acknowledged only after HOLD ends.
